// File: rtl/reshape_dispatch_pkg.sv
// Shared definitions for the reshape dispatcher: parameter defaults, FSM
// state encoding and a one-hot test helper sized for the widest legal op count.
package reshape_dispatch_pkg;

  localparam int unsigned DEF_NUM_OPS = 4;
  localparam int unsigned DEF_STATE_W = 8;
  localparam int unsigned DEF_TMO_W   = 16;
  localparam int unsigned MAX_OPS     = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_IRQ  = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  // True when exactly one bit is set; callers zero-extend to MAX_OPS.
  function automatic logic is_onehot(input logic [MAX_OPS-1:0] v);
    return (v != '0) && ((v & (v - {{(MAX_OPS-1){1'b0}}, 1'b1})) == '0);
  endfunction

endpackage

// File: rtl/reshape_watchdog.sv
// Watchdog counter for a running reshape op.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clear    : zero the counter (takes priority over enable)
//   enable   : count one cycle; also qualifies expire
//   limit    : cycle limit, 0 disables expiry
//   expire   : combinational, high on the enabled cycle where count == limit-1
module reshape_watchdog #(
  parameter int unsigned TMO_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [TMO_W-1:0] limit,
  output logic             expire
);

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + TMO_W'(1);
    end
  end

  assign expire = enable && (limit != '0) && (cnt == limit - TMO_W'(1));

endmodule

// File: rtl/reshape_dispatch.sv
// Reshape operation dispatcher: accepts a one-hot op command, pulses the
// start/DMA strobes, waits for that op's completion (guarded by a watchdog),
// then waits for an all-ones interrupt acknowledge before returning to idle.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   Control_Reshape   : one-hot op command; all-ones = interrupt acknowledge
//   Complete          : per-op completion (level or pulse)
//   Timeout_Limit     : watchdog limit in cycles, 0 disables
//   Start_Reshape     : one-cycle start pulse for the selected op
//   State             : registered status code (lags the FSM by one cycle)
//   DMA_read_valid, DMA_write_valid, DMA_read_valid_2 : op-start pulses
//   End_Control       : inverse of the last one-hot command
//   Next_Reg          : pulse on normal acknowledge out of IRQ
//   Busy              : FSM not idle
//   Err_Timeout       : sticky watchdog flag, cleared on leaving ERR
//   Err_Illegal       : pulse on a malformed command in idle
module reshape_dispatch
  import reshape_dispatch_pkg::*;
#(
  parameter int unsigned NUM_OPS = DEF_NUM_OPS,
  parameter int unsigned STATE_W = DEF_STATE_W,
  parameter int unsigned TMO_W   = DEF_TMO_W,
  parameter logic [NUM_OPS-1:0] RD2_MASK = NUM_OPS'(1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_OPS-1:0] Control_Reshape,
  input  logic [NUM_OPS-1:0] Complete,
  input  logic [TMO_W-1:0]   Timeout_Limit,
  output logic [NUM_OPS-1:0] Start_Reshape,
  output logic [STATE_W-1:0] State,
  output logic               DMA_read_valid,
  output logic               DMA_write_valid,
  output logic               DMA_read_valid_2,
  output logic [NUM_OPS-1:0] End_Control,
  output logic               Next_Reg,
  output logic               Busy,
  output logic               Err_Timeout,
  output logic               Err_Illegal
);

  state_e             state_q, state_d;
  logic [NUM_OPS-1:0] op_q, op_d;
  logic [TMO_W-1:0]   lim_q, lim_d;

  logic [MAX_OPS-1:0] ctrl_ext;
  logic               cmd_onehot, cmd_ack, cmd_zero;

  logic               wd_clear, wd_expire;

  logic [NUM_OPS-1:0] start_d;
  logic               dma_d, rd2_d, next_reg_d, illegal_d, tmo_d;
  logic [STATE_W-1:0] code_d;
  logic [NUM_OPS-1:0] end_ctrl_d;

  always_comb begin
    ctrl_ext = '0;
    ctrl_ext[NUM_OPS-1:0] = Control_Reshape;
  end

  assign cmd_onehot = is_onehot(ctrl_ext);
  assign cmd_ack    = &Control_Reshape;
  assign cmd_zero   = (Control_Reshape == '0);

  reshape_watchdog #(
    .TMO_W(TMO_W)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .clear (wd_clear),
    .enable(state_q == ST_RUN),
    .limit (lim_q),
    .expire(wd_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      lim_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      lim_q   <= lim_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    lim_d      = lim_q;
    start_d    = '0;
    dma_d      = 1'b0;
    rd2_d      = 1'b0;
    next_reg_d = 1'b0;
    illegal_d  = 1'b0;
    tmo_d      = Err_Timeout;
    wd_clear   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_onehot) begin
          state_d  = ST_RUN;
          op_d     = Control_Reshape;
          lim_d    = Timeout_Limit;
          start_d  = Control_Reshape;
          dma_d    = 1'b1;
          rd2_d    = |(Control_Reshape & RD2_MASK);
          wd_clear = 1'b1;
        end else if (!cmd_zero && !cmd_ack) begin
          illegal_d = 1'b1;
        end
      end
      ST_RUN: begin
        // Completion is checked first so it wins over a same-cycle expiry.
        if (|(Complete & op_q)) begin
          state_d = ST_IRQ;
        end else if (wd_expire) begin
          state_d = ST_ERR;
          tmo_d   = 1'b1;
        end
      end
      ST_IRQ: begin
        if (cmd_ack) begin
          state_d    = ST_IDLE;
          next_reg_d = 1'b1;
        end
      end
      ST_ERR: begin
        if (cmd_ack) begin
          state_d = ST_IDLE;
          tmo_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    code_d = '0;
    case (state_q)
      ST_RUN:  code_d[NUM_OPS-1:0] = op_q;
      ST_IRQ:  code_d[NUM_OPS-1:0] = '1;
      ST_ERR:  code_d = '1;
      default: code_d = '0;
    endcase

    end_ctrl_d = cmd_onehot ? ~Control_Reshape : End_Control;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Start_Reshape    <= '0;
      State            <= '0;
      DMA_read_valid   <= 1'b0;
      DMA_write_valid  <= 1'b0;
      DMA_read_valid_2 <= 1'b0;
      End_Control      <= '1;
      Next_Reg         <= 1'b0;
      Err_Timeout      <= 1'b0;
      Err_Illegal      <= 1'b0;
    end else begin
      Start_Reshape    <= start_d;
      State            <= code_d;
      DMA_read_valid   <= dma_d;
      DMA_write_valid  <= dma_d;
      DMA_read_valid_2 <= rd2_d;
      End_Control      <= end_ctrl_d;
      Next_Reg         <= next_reg_d;
      Err_Timeout      <= tmo_d;
      Err_Illegal      <= illegal_d;
    end
  end

  assign Busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_reshape_dispatch.sv
// Randomised plus directed bench for reshape_dispatch with a queue-based
// scoreboard fed by a transaction-level reference model.
module tb_reshape_dispatch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  ctrl = '0;
  logic [3:0]  cmp = '0;
  logic [15:0] lim = '0;

  logic [3:0]  start;
  logic [7:0]  state;
  logic        rd, wr, rd2;
  logic [3:0]  endc;
  logic        next_reg, busy, tmo, ill;

  reshape_dispatch #(
    .NUM_OPS (4),
    .STATE_W (8),
    .TMO_W   (16),
    .RD2_MASK(4'b0001)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .Control_Reshape (ctrl),
    .Complete        (cmp),
    .Timeout_Limit   (lim),
    .Start_Reshape   (start),
    .State           (state),
    .DMA_read_valid  (rd),
    .DMA_write_valid (wr),
    .DMA_read_valid_2(rd2),
    .End_Control     (endc),
    .Next_Reg        (next_reg),
    .Busy            (busy),
    .Err_Timeout     (tmo),
    .Err_Illegal     (ill)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] start;
    logic [7:0] state;
    logic       rd, wr, rd2;
    logic [3:0] endc;
    logic       next_reg, busy, tmo, ill;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: mode 0=idle 1=run 2=irq 3=err; m_cnt is the 1-based
  // number of the current cycle spent running.
  int         m_mode = 0;
  int         m_op   = 0;
  int         m_lim  = 0;
  int         m_cnt  = 0;
  logic [3:0] m_end  = 4'hF;
  logic       m_tmo  = 1'b0;

  function automatic logic [7:0] code_of(input int mode, input int op);
    case (mode)
      1:       return 8'(1) << op;
      2:       return 8'h0F;
      3:       return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv)
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, expv, $time);
    else
      n_pass++;
  endtask

  task automatic cyc(input logic r, input logic [3:0] c, input logic [3:0] cp, input logic [15:0] l);
    exp_t e;
    @(negedge clk);
    rst = r; ctrl = c; cmp = cp; lim = l;
    e.start = '0; e.rd = 0; e.wr = 0; e.rd2 = 0; e.next_reg = 0; e.ill = 0;
    if (r) begin
      m_mode = 0; m_end = 4'hF; m_tmo = 0;
      e.state = '0;
    end else begin
      e.state = code_of(m_mode, m_op);
      if ($countones(c) == 1) m_end = ~c;
      case (m_mode)
        0: begin
          if ($countones(c) == 1) begin
            for (int i = 0; i < 4; i++) if (c[i]) m_op = i;
            m_lim = int'(l); m_cnt = 0; m_mode = 1;
            e.start = c; e.rd = 1; e.wr = 1; e.rd2 = (m_op == 0);
          end else if (c != 4'h0 && c != 4'hF) begin
            e.ill = 1;
          end
        end
        1: begin
          m_cnt++;
          if (cp[m_op]) m_mode = 2;
          else if (m_lim != 0 && m_cnt == m_lim) begin m_mode = 3; m_tmo = 1; end
        end
        2: if (c == 4'hF) begin m_mode = 0; e.next_reg = 1; end
        default: if (c == 4'hF) begin m_mode = 0; m_tmo = 0; end
      endcase
    end
    e.endc = m_end;
    e.tmo  = m_tmo;
    e.busy = (m_mode != 0);
    exp_q.push_back(e);
  endtask

  // Monitor: every output is valid each cycle, so pop one expectation per edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("start",    32'(start),    32'(e.start));
        chk("state",    32'(state),    32'(e.state));
        chk("dma_rd",   32'(rd),       32'(e.rd));
        chk("dma_wr",   32'(wr),       32'(e.wr));
        chk("dma_rd2",  32'(rd2),      32'(e.rd2));
        chk("end_ctrl", 32'(endc),     32'(e.endc));
        chk("next_reg", 32'(next_reg), 32'(e.next_reg));
        chk("busy",     32'(busy),     32'(e.busy));
        chk("err_tmo",  32'(tmo),      32'(e.tmo));
        chk("err_ill",  32'(ill),      32'(e.ill));
      end
    end
  end

  initial begin
    logic        r;
    logic [3:0]  c, cp;
    logic [15:0] l;
    int          p;

    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);

    // op 1, complete after 5 cycles, acknowledge
    cyc(0, 4'b0010, 0, 0);
    repeat (5) cyc(0, 0, 0, 0);
    cyc(0, 0, 4'b0010, 0);
    repeat (2) cyc(0, 0, 0, 0);
    cyc(0, 4'hF, 0, 0);
    repeat (2) cyc(0, 0, 0, 0);

    // op 0 drives the second read strobe
    cyc(0, 4'b0001, 0, 0);
    repeat (2) cyc(0, 0, 0, 0);
    cyc(0, 0, 4'b0001, 0);
    cyc(0, 4'hF, 0, 0);
    cyc(0, 0, 0, 0);

    // watchdog expiry with limit 10
    cyc(0, 4'b0100, 0, 16'd10);
    repeat (12) cyc(0, 0, 0, 16'd10);
    cyc(0, 4'hF, 0, 0);
    repeat (2) cyc(0, 0, 0, 0);

    // completion on the 10th run cycle beats the watchdog
    cyc(0, 4'b0100, 0, 16'd10);
    repeat (9) cyc(0, 0, 0, 16'd10);
    cyc(0, 0, 4'b0100, 16'd10);
    repeat (2) cyc(0, 0, 0, 0);
    cyc(0, 4'hF, 0, 0);
    cyc(0, 0, 0, 0);

    // illegal command, then foreign completion and new command ignored in run
    cyc(0, 4'b0110, 0, 0);
    repeat (2) cyc(0, 0, 0, 0);
    cyc(0, 4'b0010, 0, 0);
    cyc(0, 0, 4'b1000, 0);
    cyc(0, 4'b0100, 4'b1000, 0);
    cyc(0, 0, 4'b0010, 0);
    cyc(0, 4'hF, 0, 0);
    cyc(0, 0, 0, 0);

    // limit of 1 expires on the first run cycle
    cyc(0, 4'b1000, 0, 16'd1);
    repeat (2) cyc(0, 0, 0, 0);
    cyc(0, 4'hF, 0, 0);

    // reset mid-run
    cyc(0, 4'b0001, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0);

    for (int n = 0; n < 600; n++) begin
      r = ($urandom_range(0, 99) == 0);
      p = int'($urandom_range(0, 99));
      if (p < 55)      c = 4'h0;
      else if (p < 72) c = 4'(1) << $urandom_range(0, 3);
      else if (p < 88) c = 4'hF;
      else             c = 4'($urandom_range(0, 15));
      cp = ($urandom_range(0, 99) < 15) ? 4'($urandom_range(0, 15)) : 4'h0;
      l  = 16'($urandom_range(0, 12));
      cyc(r, c, cp, l);
    end

    repeat (2) @(posedge clk);
    #2;
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
